// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 3;
  localparam int unsigned DefaultNumRd = 2;

  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One registered read port: array mux, zero-register masking and, when
// REGFILE_MP_BYPASS_EN is defined, write-first forwarding from the write port.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned DEPTH    = depth_of(ADDR_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  input  logic              fwd_en_i,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_q;
  logic              zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);

`ifndef REGFILE_MP_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_en_i, fwd_addr_i, fwd_data_i};
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (zero_hit) begin
        rd_data_d = '0;
`ifdef REGFILE_MP_BYPASS_EN
      end else if (fwd_en_i && (fwd_addr_i == rd_addr_i)) begin
        rd_data_d = fwd_data_i;
`endif
      end else begin
        rd_data_d = mem_i[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write ack and a one-entry-per-cycle clear sweep.
// Optional macro REGFILE_MP_BYPASS_EN selects write-first forwarding on collisions.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned NUM_RD   = DefaultNumRd,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     wr_ack_o,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  clr_state_t        state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_ack_q, clr_busy_q;
  logic              wr_acc, wr_commit;

  // Writes to the zero register are acked but never reach the array.
  assign wr_acc    = wr_en_i && (state_q == CLR_IDLE);
  assign wr_commit = wr_acc && !((ZERO_REG != 0) && (wr_addr_i == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CLR_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      wr_ack_q   <= 1'b0;
    end else begin
      wr_ack_q <= wr_acc;
      unique case (state_q)
        CLR_IDLE: begin
          if (clr_req_i) begin
            state_q    <= CLR_SWEEP;
            idx_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q    <= CLR_IDLE;
            clr_busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == CLR_SWEEP) begin
      mem_q[idx_q] <= '0;
    end else if (wr_commit) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .DEPTH   (DEPTH)
    ) u_rdport (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rd_en_i   (rd_en_i[p]),
      .rd_addr_i (rd_addr_i[p*ADDR_W +: ADDR_W]),
      .mem_i     (mem_q),
      .fwd_en_i  (wr_commit),
      .fwd_addr_i(wr_addr_i),
      .fwd_data_i(wr_data_i),
      .rd_data_o (rd_data_o[p*DATA_W +: DATA_W]),
      .rd_valid_o(rd_valid_o[p])
    );
  end

  assign wr_ack_o   = wr_ack_q;
  assign clr_busy_o = clr_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_REG 0 and 1) against a behavioural model.
module tb_regfile_mp;

  logic        clk, rst_n;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        clr_req;

  logic [15:0] d0_rd_data, d1_rd_data;
  logic [1:0]  d0_rd_valid, d1_rd_valid;
  logic        d0_wr_ack, d1_wr_ack, d0_clr_busy, d1_clr_busy;

  int n_total = 0;
  int n_bad   = 0;

  regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(d0_rd_data), .rd_valid_o(d0_rd_valid), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(d0_wr_ack),
    .clr_req_i(clr_req), .clr_busy_o(d0_clr_busy)
  );

  regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(d1_rd_data), .rd_valid_o(d1_rd_valid), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(d1_wr_ack),
    .clr_req_i(clr_req), .clr_busy_o(d1_clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: array contents per instance, sweep as a count of remaining cycles.
  logic [7:0] m_mem  [2][8];
  logic [7:0] m_data [2][2];
  logic [1:0] m_valid;
  logic       m_ack;
  int         m_left;
  wire        m_acc = wr_en && (m_left == 0);

  function automatic logic [7:0] m_rd(input int k, input logic [2:0] ra);
    if (k == 1 && ra == 3'd0) return 8'h00;
`ifdef REGFILE_MP_BYPASS_EN
    if (m_acc && ra == wr_addr) return wr_data;
`endif
    return m_mem[k][ra];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 8; a++) m_mem[k][a] <= 8'h00;
        m_data[k][0] <= 8'h00;
        m_data[k][1] <= 8'h00;
      end
      m_valid <= 2'b00;
      m_ack   <= 1'b0;
      m_left  <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 2; p++)
          if (rd_en[p]) m_data[k][p] <= m_rd(k, rd_addr[p*3 +: 3]);
        if (m_acc && !(k == 1 && wr_addr == 3'd0)) m_mem[k][wr_addr] <= wr_data;
        if (m_left != 0) m_mem[k][8 - m_left] <= 8'h00;
      end
      m_valid <= rd_en;
      m_ack   <= m_acc;
      if (m_left != 0) m_left <= m_left - 1;
      else if (clr_req) m_left <= 8;
    end
  end

  logic [15:0] dut_data [2];
  logic [1:0]  dut_valid [2];
  logic        dut_ack [2], dut_busy [2];
  assign dut_data[0]  = d0_rd_data;
  assign dut_data[1]  = d1_rd_data;
  assign dut_valid[0] = d0_rd_valid;
  assign dut_valid[1] = d1_rd_valid;
  assign dut_ack[0]   = d0_wr_ack;
  assign dut_ack[1]   = d1_wr_ack;
  assign dut_busy[0]  = d0_clr_busy;
  assign dut_busy[1]  = d1_clr_busy;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_rd_data%0d", k), dut_data[k], {m_data[k][1], m_data[k][0]});
      check($sformatf("model_rd_valid%0d", k), {14'd0, dut_valid[k]}, {14'd0, m_valid});
      check($sformatf("model_wr_ack%0d", k), {15'd0, dut_ack[k]}, {15'd0, m_ack});
      check($sformatf("model_clr_busy%0d", k), {15'd0, dut_busy[k]},
            {15'd0, (m_left != 0)});
    end
  end

  task automatic cyc(input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1,
                     input logic we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic cr);
    rd_en   = re;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    clr_req = cr;
    @(negedge clk);
  endtask

  int busy_cnt;
  int guard;

  initial begin
    rst_n = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rd_data", d0_rd_data, 16'h0000);
    check("reset_flags", {12'd0, d0_rd_valid, d0_wr_ack, d0_clr_busy}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 8; a++) begin
      cyc(2'b11, 3'(a), 3'(a), 1'b0, 3'd0, 8'h00, 1'b0);
      check("init_read", d0_rd_data, 16'h0000);
      check("init_valid", {14'd0, d0_rd_valid}, 16'h0003);
    end
    cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("valid_pulse_drop", {14'd0, d0_rd_valid}, 16'h0000);

    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0);
    check("a5_ack", {15'd0, d0_wr_ack}, 16'h0001);
    cyc(2'b01, 3'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("a5_port0", {8'd0, d0_rd_data[7:0]}, 16'h00A5);
    cyc(2'b10, 3'd0, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0);
    check("a5_port1_hold0", d0_rd_data, 16'hA5A5);
    check("a5_valid", {14'd0, d0_rd_valid}, 16'h0002);

    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd5, 8'h11, 1'b0);
    cyc(2'b01, 3'd5, 3'd0, 1'b1, 3'd5, 8'h3C, 1'b0);
`ifdef REGFILE_MP_BYPASS_EN
    check("collision", {8'd0, d0_rd_data[7:0]}, 16'h003C);
`else
    check("collision", {8'd0, d0_rd_data[7:0]}, 16'h0011);
`endif
    cyc(2'b01, 3'd5, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("after_collision", {8'd0, d0_rd_data[7:0]}, 16'h003C);

    for (int a = 0; a < 8; a++) cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'(a), 8'(8'h20 + a), 1'b0);
    cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    busy_cnt = 0;
    guard = 0;
    while (d0_clr_busy && guard < 20) begin
      busy_cnt++;
      guard++;
      if (busy_cnt == 3) begin
        cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd6, 8'h77, 1'b0);
        check("sweep_write_noack", {15'd0, d0_wr_ack}, 16'h0000);
      end else begin
        cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
      end
    end
    check("sweep_busy_cycles", 16'(busy_cnt), 16'd8);
    for (int a = 0; a < 8; a++) begin
      cyc(2'b11, 3'(a), 3'(a), 1'b0, 3'd0, 8'h00, 1'b0);
      check("post_sweep_read", d0_rd_data, 16'h0000);
    end
    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd1, 8'h42, 1'b0);
    check("first_write_after_sweep", {15'd0, d0_wr_ack}, 16'h0001);

    cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b0);
    check("zero_reg_ack", {15'd0, d1_wr_ack}, 16'h0001);
    cyc(2'b11, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);
    check("zero_reg_read", d1_rd_data, 16'h0000);
    check("nonzero_inst_read0", d0_rd_data, 16'hFFFF);

    for (int a = 0; a < 8; a++)
      cyc(2'b00, 3'd0, 3'd0, 1'b1, 3'(a), 8'(8'h11 * (a + 1)), 1'b0);
    cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1);
    repeat (4) cyc(2'b11, 3'd7, 3'd7, 1'b0, 3'd0, 8'h00, 1'b0);
    check("pre_abort_read", d0_rd_data, 16'h8888);
    check("pre_abort_busy", {15'd0, d0_clr_busy}, 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rd_data", d0_rd_data, 16'h0000);
    check("abort_flags", {12'd0, d0_rd_valid, d0_wr_ack, d0_clr_busy}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      cyc(2'b11, 3'(a), 3'(a), 1'b0, 3'd0, 8'h00, 1'b0);
      check("post_abort_read", d0_rd_data, 16'h0000);
    end
    check("post_abort_busy", {15'd0, d0_clr_busy}, 16'h0000);
    cyc(2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the team's 8×8 register file. It provides NUM_RD independent synchronous read ports, one write port with an acknowledge pulse, an optional hard-wired zero register, and a hardware clear sequencer that zeroes the array one entry per cycle. Reads and writes now share a single clock edge. The block sits between instruction decode (read ports) and writeback (write port) in the processor datapath.

## Interface
- DATA_W, 8: word width in bits
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2: number of read ports, ≥1
- ZERO_REG, 0: 1 = entry 0 always reads 0 and writes to it are discarded (but still acked)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port p at [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  1-cycle pulse: rd_data[p] was updated this cycle
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  1-cycle pulse: write accepted in the previous cycle
- clr_req  in  1  start the clear sweep; sampled only in IDLE
- clr_busy  out  1  high while the sweep runs

## Operation
- Reset (rst_n low, asynchronous): all array entries = 0; rd_data = 0; rd_valid = 0; wr_ack = 0; clr_busy = 0; FSM = IDLE; sweep index = 0.
- Read: on an edge with rd_en[p]=1, rd_data[p] <= array[rd_addr[p]]; rd_valid[p] <= 1. With rd_en[p]=0, rd_data[p] holds its value and rd_valid[p] <= 0. Ports are fully independent; identical addresses on several ports are legal.
- Write: on an edge with wr_en=1 and FSM=IDLE, array[wr_addr] <= wr_data; wr_ack <= 1. Otherwise wr_ack <= 0.
- ZERO_REG=1: reads of address 0 return 0. Writes to address 0 leave the array unchanged but still produce wr_ack.
- Read/write collision (same edge, same address): behaviour is set by the configuration macro (see Configuration).
- Clear FSM has two states, IDLE and SWEEP:
  - IDLE -> SWEEP when clr_req=1. clr_busy goes high on the following cycle, and the index is 0.
  - In SWEEP, each edge performs array[idx] <= 0 and idx <= idx+1.
  - When idx = DEPTH-1, that entry is zeroed and the FSM returns to IDLE; clr_busy drops on the same edge.
- During SWEEP:
  - wr_en is ignored: no array change and wr_ack=0. The requester must retry.
  - clr_req is ignored.
  - Reads proceed and return current contents, so entries below idx already read 0.
- Reset asserted mid-sweep aborts the sweep immediately to the reset state.

## Timing
- Read latency is 1 cycle: address and enable at edge N give data and valid after edge N.
- Write takes effect at edge N. wr_ack is high for the cycle following edge N.
- Read-after-write to the same address at edge N+1 returns the new data.
- A sweep occupies exactly DEPTH cycles, with clr_busy high for DEPTH cycles. The first write accepted is the one presented at the edge on which clr_busy is sampled low again.
- The index wraps naturally at DEPTH. No arithmetic beyond the ADDR_W-bit increment.

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- Defined: write-first forwarding. If wr_en is accepted and rd_addr[p]==wr_addr on the same edge with rd_en[p]=1, then rd_data[p] <= wr_data. Forwarding is suppressed for address 0 when ZERO_REG=1, and during SWEEP.
- Undefined: read-first. The read returns the pre-write contents, and the new value is visible from the next read.

## Structure
- The shared package holds:
  - FSM state enum clr_state_t {CLR_IDLE, CLR_SWEEP}
  - localparam helper DEPTH(ADDR_W)
  - default width constants
- Sub-module regfile_mp_rdport holds one read port: mux, optional bypass compare, and output/valid registers. It is instantiated NUM_RD times in a generate loop.
- The array, write logic and clear FSM live in the top level.

## Test plan
- After reset, all NUM_RD=2 ports read every address -> 0 each, rd_valid pulses once per enable.
- Write 0xA5 to addr 3 -> wr_ack high the next cycle. Port0 reads addr 3 while port1 reads addr 3 the following cycle -> both 0xA5.
- Same-edge write 0x3C to addr 5 with a read of addr 5 (old value 0x11) -> 0x3C with the macro defined, 0x11 without.
- Fill all 8 entries, pulse clr_req, then issue a write during the sweep:
  - clr_busy is high for exactly 8 cycles
  - the write gets no ack
  - all entries read 0 afterwards
- With ZERO_REG=1, write 0xFF to addr 0 -> wr_ack=1, and a subsequent read returns 0x00.
- Drop rst_n mid-sweep at idx 4 -> outputs zero immediately, FSM IDLE, clr_busy 0, and all entries read 0.
